// File: rtl/int_ctrl.sv
// int_ctrl: edge-triggered interrupt request controller with a one-deep
// pending latch and a saturating count of coalesced/lost interrupt edges.
//
// Optional input filter: define INT_CTRL_DEBOUNCE_EN to insert a debounce
// filter between the synchronizer and the edge detector.
//
// Ports:
//   clk         in   1  clock, rising-edge active
//   reset       in   1  asynchronous active-low reset
//   irq_in      in   1  external interrupt line (asynchronous to clk)
//   int_ack     in   1  CPU accepts the pending request (1-cycle pulse)
//   rti_done    in   1  CPU finished the interrupt return (1-cycle pulse)
//   clr_cnt     in   1  synchronous clear of drop_cnt
//   interrupt   out  1  registered request to the CPU
//   in_service  out  1  registered, high while the CPU is servicing
//   drop_cnt    out  8  saturating count of coalesced/lost rising edges
module int_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq_in,
  input  logic       int_ack,
  input  logic       rti_done,
  input  logic       clr_cnt,
  output logic       interrupt,
  output logic       in_service,
  output logic [7:0] drop_cnt
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DB_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVICE = 2'd2
  } state_e;

  // Elaboration-time guard on the filter length.
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
    $error("int_ctrl: DEBOUNCE_CYCLES must be in 2..15");
  end

  // Two-flop synchronizer for the asynchronous interrupt line.
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  logic rise_c;

`ifdef INT_CTRL_DEBOUNCE_EN
  // Debounce filter: filt_q follows sync2_q only after DEBOUNCE_CYCLES
  // consecutive samples that differ from the current filtered level.
  logic            filt_q, filt_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // The edge is taken from the filter's next level so the FSM reacts on
  // the same clock edge the filtered level flips; filt_q is its previous value.
  assign rise_c = filt_d & ~filt_q;
`else
  // Previous synchronized level for rising-edge detection.
  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sync2_q;
    end
  end

  assign rise_c = sync2_q & ~prev_q;
`endif

  // Request FSM state, one-deep pending latch and drop counter.
  state_e           state_q, state_d;
  logic             latch_q, latch_d;
  logic             drop_inc_c;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             interrupt_q, in_service_q;

  always_comb begin
    state_d    = state_q;
    latch_d    = latch_q;
    drop_inc_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise_c) state_d = PENDING;
      end
      PENDING: begin
        if (int_ack) begin
          state_d = SERVICE;
          // An edge arriving with the ack is remembered, not lost.
          if (rise_c) latch_d = 1'b1;
        end else if (rise_c) begin
          drop_inc_c = 1'b1;
        end
      end
      SERVICE: begin
        if (rti_done) begin
          if (rise_c) begin
            // New edge re-arms the request; an already latched one is lost.
            state_d    = PENDING;
            latch_d    = 1'b0;
            drop_inc_c = latch_q;
          end else if (latch_q) begin
            state_d = PENDING;
            latch_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (rise_c) begin
          if (latch_q) drop_inc_c = 1'b1;
          else         latch_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        latch_d = 1'b0;
      end
    endcase
  end

  // Saturating drop counter; clear wins over increment.
  always_comb begin
    drop_d = drop_q;
    if (clr_cnt) begin
      drop_d = '0;
    end else if (drop_inc_c && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      latch_q      <= 1'b0;
      drop_q       <= '0;
      interrupt_q  <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      latch_q      <= latch_d;
      drop_q       <= drop_d;
      interrupt_q  <= (state_d == PENDING);
      in_service_q <= (state_d == SERVICE);
    end
  end

  assign interrupt  = interrupt_q;
  assign in_service = in_service_q;
  assign drop_cnt   = drop_q;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 4, consecutive stable samples needed to change the filtered level (used only with INT_CTRL_DEBOUNCE_EN; legal range 2..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on the rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: irq_in  input  1  external interrupt line, asynchronous to clk.
REQ-005 SHALL have port: int_ack  input  1  one-cycle pulse from the CPU accepting the request.
REQ-006 SHALL have port: rti_done  input  1  one-cycle pulse from the CPU at interrupt-return completion.
REQ-007 SHALL have port: clr_cnt  input  1  synchronous clear of drop_cnt.
REQ-008 SHALL have port: interrupt  output  1  registered request to the CPU interrupt input.
REQ-009 SHALL have port: in_service  output  1  registered, high while the CPU is servicing.
REQ-010 SHALL have port: drop_cnt  output  8  count of coalesced/lost rising edges.

Function
REQ-011 SHALL pass irq_in through a two-flop synchronizer before any other use.
REQ-012 SHALL detect a rising edge as synchronized (or filtered) level high with its previous-cycle value low; one detected edge per low-to-high transition.
REQ-013 SHALL implement states IDLE, PENDING, SERVICE; interrupt = (state==PENDING), in_service = (state==SERVICE), both registered.
REQ-014 IDLE: edge -> PENDING; int_ack and rti_done ignored.
REQ-015 PENDING: int_ack -> SERVICE, interrupt low on the same edge that in_service goes high; an edge without int_ack increments drop_cnt (coalesced).
REQ-016 PENDING with edge and int_ack on the same cycle: -> SERVICE and set the one-deep pending latch; drop_cnt unchanged.
REQ-017 SERVICE: edge with latch clear sets the latch; edge with latch already set increments drop_cnt; int_ack ignored.
REQ-018 SERVICE with rti_done: latch set -> PENDING and clear latch; latch clear -> IDLE.
REQ-019 SERVICE with rti_done and edge on the same cycle: -> PENDING; edge not counted as dropped; if latch was also set, drop_cnt increments by 1.
REQ-020 Latency: first rising clk edge that samples irq_in high = edge k; interrupt SHALL be high after edge k+2 (no debounce), IDLE start.
REQ-021 drop_cnt SHALL saturate at 8'hFF, never wrap.
REQ-022 clr_cnt SHALL force drop_cnt to 0 next edge, taking priority over a simultaneous increment.
REQ-023 interrupt SHALL stay high in PENDING until int_ack, with no timeout.

Reset
REQ-024 reset low SHALL immediately force state IDLE, interrupt 0, in_service 0, drop_cnt 0, latch 0, synchronizer/filter/edge registers 0.
REQ-025 Reset asserted mid-service SHALL discard the pending latch; after release, irq_in held high SHALL produce a new edge (previous sample reset to 0).
REQ-026 Release SHALL take effect on the first rising clk edge after reset goes high.

Configuration
REQ-027 Macro INT_CTRL_DEBOUNCE_EN defined: synchronized level SHALL feed a filter whose output changes only after DEBOUNCE_CYCLES consecutive equal samples; pulses shorter than that are ignored; interrupt high after edge k+1+DEBOUNCE_CYCLES.
REQ-028 Macro not defined: no filter logic; synchronized level feeds edge detection directly; DEBOUNCE_CYCLES unused.

Verification
REQ-029 Reset release, irq_in 0->1 at edge k -> interrupt=1 after edge k+2, in_service=0, drop_cnt=0.
REQ-030 PENDING, three further irq_in pulses (3 cycles high/low each) before int_ack -> drop_cnt=3; int_ack -> interrupt=0, in_service=1.
REQ-031 SERVICE, two irq_in pulses then rti_done -> drop_cnt+1, state PENDING, interrupt=1 next edge; int_ack then rti_done -> IDLE.
REQ-032 300 coalesced edges in PENDING -> drop_cnt=8'hFF; clr_cnt together with an edge -> drop_cnt=0.
REQ-033 reset low mid-SERVICE with latch set -> all outputs 0 immediately; irq_in held high through release -> interrupt=1 two edges after the first post-release edge.
REQ-034 INT_CTRL_DEBOUNCE_EN, DEBOUNCE_CYCLES=4: 3-cycle irq_in pulse -> no interrupt; 6-cycle pulse -> interrupt=1 after edge k+5.
